// File: rtl/ir_queue.sv
// ir_queue: FIFO of fetched instruction words with the head presented as decoded MIPS fields
//   Parameters: DEPTH (entries, power of 2, >= 2), RESET_INSTR (head word while empty)
//   Inputs : clk, rst_n (async active-low), flush, wr_en/wr_data (push), rd_en (pop)
//   Outputs: full, empty, count, ovf (sticky push-while-full), instr, op/rs/rt/rd/shamt/funct/imm
//   Option : IR_QUEUE_PC_TAG_EN adds wr_pc input and head_pc output (PC tag per entry)
module ir_queue #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
`ifdef IR_QUEUE_PC_TAG_EN
    input  logic [31:0]   wr_pc,
    output logic [31:0]   head_pc,
`endif
    input  logic          rd_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic [31:0]   instr,
    output logic [5:0]    op,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic [4:0]    rd,
    output logic [4:0]    shamt,
    output logic [5:0]    funct,
    output logic [15:0]   imm
);
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;
    // a full queue still accepts a push when the head leaves in the same cycle
    assign push = wr_en && (!full || rd_en);
    assign pop  = rd_en && !empty;
    always_comb begin
        wr_ptr_d = flush ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = flush ? '0 : (push && !pop) ? count_q + (AW+1)'(1) :
                   (pop && !push) ? count_q - (AW+1)'(1) : count_q;
        ovf_d    = flush ? 1'b0 : (ovf_q || (wr_en && full && !rd_en));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end
    // storage needs no reset: it is only visible through the head mux when non-empty
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end
`ifdef IR_QUEUE_PC_TAG_EN
    logic [31:0] pc_q [DEPTH];
    always_ff @(posedge clk) begin
        if (push && !flush) pc_q[wr_ptr_q] <= wr_pc;
    end
    assign head_pc = empty ? 32'h0 : pc_q[rd_ptr_q];
`endif
    assign count = count_q;
    assign ovf   = ovf_q;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign instr = empty ? RESET_INSTR : mem_q[rd_ptr_q];
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];
endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised successor to the multi-cycle CPU's single instruction register.
- Holds up to DEPTH fetched instruction words in FIFO order.
- The head entry is presented as decoded MIPS fields: op, rs, rt, rd, shamt, funct, imm.
- Sits between instruction memory and the control FSM/register file, so fetch can run ahead of decode.

Parameters:
DEPTH, 4, number of instruction entries; power of 2, minimum 2
RESET_INSTR, 32'h0000_0000, word presented on the head fields while the queue is empty (default is a NOP)
AW, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous discard of all entries
wr_en  input  1  push request (IRWrite successor)
wr_data  input  32  instruction word from memory
rd_en  input  1  pop request from decode
full  output  1  DEPTH entries held
empty  output  1  0 entries held
count  output  AW+1  current occupancy, 0..DEPTH
ovf  output  1  sticky: a push was attempted while full
instr  output  32  head word, or RESET_INSTR when empty
op  output  6  instr[31:26]
rs  output  5  instr[25:21]
rt  output  5  instr[20:16]
rd  output  5  instr[15:11]
shamt  output  5  instr[10:6]
funct  output  6  instr[5:0]
imm  output  16  instr[15:0]

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - empty=1, full=0, ovf=0.
  - instr=RESET_INSTR; all decoded fields are slices of it.
  - Storage contents are don't-care; they are never observable while empty.
- Storage: DEPTH x 32 register array. Pointers are AW bits and wrap naturally from DEPTH-1 to 0.
- Push accepted = wr_en && (!full || rd_en). Effects at the edge: mem[wr_ptr]<=wr_data, wr_ptr+1.
- Pop accepted = rd_en && !empty. Effect at the edge: rd_ptr+1.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Full with simultaneous wr_en and rd_en: both are accepted and count stays DEPTH.
- Empty with simultaneous wr_en and rd_en: push accepted, pop ignored (no bypass), count becomes 1.
- Push while full without rd_en: word dropped, state unchanged, ovf set to 1.
  - ovf clears only on reset or flush.
- Pop while empty: ignored, no state change.
- flush: pointers, count and ovf go to 0 at the edge.
  - flush has priority over wr_en and rd_en in the same cycle; a simultaneous push is discarded.
- full = (count==DEPTH), empty = (count==0). Both are combinational from count.
- Head outputs are combinational from mem[rd_ptr], muxed to RESET_INSTR when empty.
- Latency: a word pushed at edge N appears on instr after edge N if the queue was empty before it.
- Head is stable while rd_en is low, whatever pushes occur (the hold property of the old IR).
- Reset asserted mid-operation discards everything immediately, with no wait for a clock edge.

Optional Feature:
- Macro: IR_QUEUE_PC_TAG_EN
- Defined:
  - Adds input wr_pc[31:0] and output head_pc[31:0].
  - wr_pc is stored alongside each word under the same push rules.
  - head_pc is the tag of the head entry, 32'h0 when empty, 32'h0 on reset.
  - Used for branch-target and exception PC on in-flight instructions.
- Undefined: the ports and tag storage are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle -> empty=1, count=0, instr=32'h0, op=0, funct=0, ovf=0.
- Push 32'h8C43_0004 (lw) into empty queue -> next cycle empty=0, count=1, op=6'h23, rs=2, rt=3, imm=16'h0004.
- Push 4 words with DEPTH=4, then a 5th push without rd_en -> full=1, count=4, ovf=1, head is still word 1. Pop all 4 -> words come out in order, then empty=1.
- Full queue with wr_en and rd_en in the same cycle -> count stays 4, head advances to word 2, new word sits last. Empty queue with both asserted -> count=1, instr=new word.
- 3 entries held, then flush together with wr_en -> empty=1, count=0, ovf=0, instr=RESET_INSTR, pushed word absent.
- Pull rst_n low between clock edges while count=2 -> outputs reach reset values before the next clk edge. Under IR_QUEUE_PC_TAG_EN, head_pc=0 at the same time.
